// File: rtl/qerv_rf_seq.sv
// Host-side initiator for the nibble-serial register-file RAM interface:
// takes a parallel read/write transaction and runs the serial request/grant/beat protocol.
module qerv_rf_seq #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int csr_regs       = 4,
  localparam int raw   = $clog2(32+csr_regs),
  localparam int BEATS = 32/BITS_PER_CYCLE
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_write,
  input  logic [raw-1:0]            i_rreg0,
  input  logic [raw-1:0]            i_rreg1,
  input  logic [raw-1:0]            i_wreg0,
  input  logic [raw-1:0]            i_wreg1,
  input  logic                      i_wen0,
  input  logic                      i_wen1,
  input  logic [31:0]               i_wdata0,
  input  logic [31:0]               i_wdata1,
  output logic                      o_rsp_valid,
  output logic [31:0]               o_rdata0,
  output logic [31:0]               o_rdata1,
  output logic                      o_rreq,
  output logic                      o_wreq,
  input  logic                      i_ready,
  output logic [raw-1:0]            o_rreg0,
  output logic [raw-1:0]            o_rreg1,
  output logic [raw-1:0]            o_wreg0,
  output logic [raw-1:0]            o_wreg1,
  output logic                      o_wen0,
  output logic                      o_wen1,
  output logic [BITS_PER_CYCLE-1:0] o_wdata0,
  output logic [BITS_PER_CYCLE-1:0] o_wdata1,
  input  logic [BITS_PER_CYCLE-1:0] i_rdata0,
  input  logic [BITS_PER_CYCLE-1:0] i_rdata1,
  output logic [2:0]                o_dbg_state
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS-1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_XFER, S_RSP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            write_q;
  logic            wen0_q, wen1_q;
  logic            rreq_q, wreq_q, rsp_q;
  logic [raw-1:0]  rreg0_q, rreg1_q, wreg0_q, wreg1_q;
  logic [31:0]     sh0_q, sh1_q;
  logic [31:0]     rdata0_q, rdata1_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      rreq_q   <= 1'b0;
      wreq_q   <= 1'b0;
      rsp_q    <= 1'b0;
      rreg0_q  <= '0;
      rreg1_q  <= '0;
      wreg0_q  <= '0;
      wreg1_q  <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rreq_q <= 1'b0;
      wreq_q <= 1'b0;
      rsp_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            write_q <= i_req_write;
            rreg0_q <= i_rreg0;
            rreg1_q <= i_rreg1;
            wreg0_q <= i_wreg0;
            wreg1_q <= i_wreg1;
            wen0_q  <= i_wen0;
            wen1_q  <= i_wen1;
            sh0_q   <= i_wdata0;
            sh1_q   <= i_wdata1;
            rreq_q  <= ~i_req_write;
            wreq_q  <= i_req_write;
            state_q <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (i_ready) begin
            cnt_q   <= '0;
            state_q <= S_XFER;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_XFER: begin
          // Writes drain LSB-first with zero fill; reads fill from the top so the
          // first (least significant) slice ends up at bit 0.
          if (write_q) begin
            sh0_q <= {{BITS_PER_CYCLE{1'b0}}, sh0_q[31:BITS_PER_CYCLE]};
            sh1_q <= {{BITS_PER_CYCLE{1'b0}}, sh1_q[31:BITS_PER_CYCLE]};
          end else begin
            sh0_q <= {i_rdata0, sh0_q[31:BITS_PER_CYCLE]};
            sh1_q <= {i_rdata1, sh1_q[31:BITS_PER_CYCLE]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            if (!write_q) begin
              rdata0_q <= {i_rdata0, sh0_q[31:BITS_PER_CYCLE]};
              rdata1_q <= {i_rdata1, sh1_q[31:BITS_PER_CYCLE]};
            end
            rsp_q   <= 1'b1;
            state_q <= S_RSP;
          end
        end
        S_RSP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic wr_xfer;
  assign wr_xfer = (state_q == S_XFER) && write_q;

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = rsp_q;
  assign o_rreq      = rreq_q;
  assign o_wreq      = wreq_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_rreg0     = rreg0_q;
  assign o_rreg1     = rreg1_q;
  assign o_wreg0     = wreg0_q;
  assign o_wreg1     = wreg1_q;
  assign o_wen0      = wr_xfer & wen0_q;
  assign o_wen1      = wr_xfer & wen1_q;
  assign o_wdata0    = wr_xfer ? sh0_q[BITS_PER_CYCLE-1:0] : '0;
  assign o_wdata1    = wr_xfer ? sh1_q[BITS_PER_CYCLE-1:0] : '0;
  assign o_dbg_state = state_q;

endmodule
